ama_riscv_store_buffer: RTL and testbench

//  Posted-write buffer between the MEM stage and DMEM, downstream of the store mask.

---
 rtl/ama_riscv_pkg.sv | 20 ++
 rtl/ama_riscv_store_align.sv | 21 ++
 rtl/ama_riscv_store_buffer.sv | 134 +++++++++++++
 tb/tb_ama_riscv_store_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_pkg.sv
// Shared types for the store buffer: entry layout, FSM states and default depth.
package ama_riscv_pkg;

  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_LANES     = 4;
  localparam int SB_LANE_W    = 8;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  we;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FENCE = 2'd2
  } sb_state_t;

endpackage

// File: rtl/ama_riscv_store_align.sv
// Byte-lane shifter: moves LSB-justified store data up to the lanes selected
// by the low address bits. Shared with the load path.
module ama_riscv_store_align #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8,
  parameter int OFF_W     = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0][LANE_W-1:0] data,
  input  logic [OFF_W-1:0]                 offset,
  output logic [NUM_LANES-1:0][LANE_W-1:0] aligned
);

  // lane l takes source lane (l - offset); lanes below the offset are zero
  always_comb begin
    aligned = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (OFF_W'(l) >= offset) aligned[l] = data[OFF_W'(l) - offset];
    end
  end

endmodule

// File: rtl/ama_riscv_store_buffer.sv
// Posted-write store buffer between MEM and DMEM with fence drain.
// Define STORE_BUF_FWD_EN to add store-to-load byte forwarding ports.
module ama_riscv_store_buffer
  import ama_riscv_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_mask,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic [29:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_we,
`ifdef STORE_BUF_FWD_EN
  input  logic [31:0]      ld_addr,
  output logic [31:0]      ld_fwd_data,
  output logic [3:0]       ld_fwd_mask,
`endif
  input  logic             fence_req,
  output logic             fence_done,
  output logic             sb_empty,
  output logic [CNT_W-1:0] sb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  sb_state_t        state, state_nxt;
  logic             full, enq, deq;
  logic [31:0]      st_wdata;

  ama_riscv_store_align #(
    .NUM_LANES (SB_LANES),
    .LANE_W    (SB_LANE_W)
  ) u_align (
    .data    (st_data),
    .offset  (st_addr[1:0]),
    .aligned (st_wdata)
  );

  // ready and req depend only on registered state, never on st_* inputs
  assign full     = (count == FULL_CNT);
  assign sb_empty = (count == '0);
  assign st_ready = !full && (state != FENCE);
  assign dmem_req = !sb_empty;
  assign enq      = st_valid && st_ready && (st_mask != 4'h0);
  assign deq      = dmem_req && dmem_ack;
  assign sb_count = count;

  assign dmem_addr  = mem[rd_ptr].waddr;
  assign dmem_wdata = mem[rd_ptr].data;
  assign dmem_we    = mem[rd_ptr].we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      state <= state_nxt;
    end
  end

  // payload needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{waddr: st_addr[31:2], data: st_wdata, we: st_mask};
  end

  always_comb begin
    state_nxt  = state;
    fence_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (fence_req)  state_nxt = FENCE;
        else if (enq)   state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fence_req)  state_nxt = FENCE;
        else if (deq && !enq && count == CNT_W'(1)) state_nxt = IDLE;
      end
      FENCE: begin
        if (sb_empty) begin
          state_nxt  = IDLE;
          fence_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef STORE_BUF_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  logic             unused_ld_off;

  assign unused_ld_off = ^ld_addr[1:0];

  // walk oldest to youngest so younger matching bytes overwrite older ones
  always_comb begin
    ld_fwd_data = '0;
    ld_fwd_mask = '0;
    fwd_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem[fwd_idx].waddr == ld_addr[31:2])) begin
        for (int b = 0; b < SB_LANES; b++) begin
          if (mem[fwd_idx].we[b]) begin
            ld_fwd_data[b*8 +: 8] = mem[fwd_idx].data[b*8 +: 8];
            ld_fwd_mask[b]        = 1'b1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ama_riscv_store_buffer.sv
// Directed + random bench for ama_riscv_store_buffer with an in-order DMEM scoreboard.
module tb_ama_riscv_store_buffer;
  import ama_riscv_pkg::*;

  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     st_valid = 1'b0;
  logic                     st_ready;
  logic [31:0]              st_addr = '0;
  logic [31:0]              st_data = '0;
  logic [3:0]               st_mask = '0;
  logic                     dmem_req;
  logic                     dmem_ack = 1'b0;
  logic [29:0]              dmem_addr;
  logic [31:0]              dmem_wdata;
  logic [3:0]               dmem_we;
  logic                     fence_req = 1'b0;
  logic                     fence_done;
  logic                     sb_empty;
  logic [$clog2(DEPTH):0]   sb_count;
`ifdef STORE_BUF_FWD_EN
  logic [31:0]              ld_addr = '0;
  logic [31:0]              ld_fwd_data;
  logic [3:0]               ld_fwd_mask;
`endif

  always #5 clk = ~clk;

  ama_riscv_store_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_mask     (st_mask),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_we     (dmem_we),
`ifdef STORE_BUF_FWD_EN
    .ld_addr     (ld_addr),
    .ld_fwd_data (ld_fwd_data),
    .ld_fwd_mask (ld_fwd_mask),
`endif
    .fence_req   (fence_req),
    .fence_done  (fence_done),
    .sb_empty    (sb_empty),
    .sb_count    (sb_count)
  );

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  we;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_fence = 1'b0;
  int   done_pulses = 0;

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    for (int b = 0; b < 4; b++) lane_mask[b*8 +: 8] = {8{we[b]}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs at the negedge against the model, update it, then
  // return 1ns after the next rising edge so the caller can drive new inputs.
  task automatic step();
    bit   e_ready, e_req, enq, deq;
    int   cnt;
    exp_t h, n;
    @(negedge clk);
    cnt     = sbq.size();
    e_ready = (cnt < DEPTH) && !m_fence;
    e_req   = (cnt != 0);
    chk("st_ready",   32'(st_ready),   32'(e_ready));
    chk("dmem_req",   32'(dmem_req),   32'(e_req));
    chk("sb_count",   32'(sb_count),   32'(cnt));
    chk("sb_empty",   32'(sb_empty),   32'(cnt == 0));
    chk("fence_done", 32'(fence_done), 32'(m_fence && cnt == 0));
    if (fence_done) done_pulses++;
    enq = st_valid && e_ready && (st_mask != 4'h0);
    deq = e_req && dmem_ack;
    if (deq) begin
      h = sbq.pop_front();
      chk("dmem_addr",  {2'b00, dmem_addr}, {2'b00, h.waddr});
      chk("dmem_we",    {28'h0, dmem_we},   {28'h0, h.we});
      chk("dmem_wdata", dmem_wdata & lane_mask(h.we), h.data & lane_mask(h.we));
    end
    if (enq) begin
      n.waddr = st_addr[31:2];
      n.data  = st_data << (8 * st_addr[1:0]);
      n.we    = st_mask;
      sbq.push_back(n);
    end
    if (m_fence && cnt == 0) m_fence = 1'b0;
    else if (!m_fence && fence_req) m_fence = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = 1'b1; st_addr = a; st_data = d; st_mask = m;
    step();
    st_valid = 1'b0;
  endtask

  task automatic drain();
    dmem_ack = 1'b1;
    for (int k = 0; k < 20 && sbq.size() != 0; k++) step();
    dmem_ack = 1'b0;
    chk("drain_empty", 32'(sb_empty), 32'd1);
  endtask

  initial begin
    // reset state
    step();
    step();
    rst_n = 1'b1;
    step();

    // SB 0xAB at 0x103 lands in lane 3 of word 0x40
    put(32'h0000_0103, 32'h0000_00AB, 4'h8);
    chk("t1_addr",  {2'b00, dmem_addr},  32'h0000_0040);
    chk("t1_byte3", {24'h0, dmem_wdata[31:24]}, 32'h0000_00AB);
    chk("t1_we",    {28'h0, dmem_we},    32'h0000_0008);
    drain();

    // fill to DEPTH with halfwords, 5th waits for a dequeue
    for (int i = 0; i < 4; i++) put(32'h200 + 32'(4*i) + 32'h2, 32'hA000 + 32'(i), 4'hC);
    chk("t2_full_ready", 32'(st_ready), 32'd0);
    st_valid = 1'b1; st_addr = 32'h210; st_data = 32'hBEEF; st_mask = 4'h3;
    step();
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("t2_ready_after_ack", 32'(st_ready), 32'd1);
    step();
    st_valid = 1'b0;
    chk("t2_count", 32'(sb_count), 32'd4);
    drain();

    // zero mask is consumed without an entry
    st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h1234; st_mask = 4'h0;
    repeat (3) step();
    st_valid = 1'b0;
    chk("t3_count", 32'(sb_count), 32'd0);
    chk("t3_req",   32'(dmem_req), 32'd0);

    // fence with 3 entries and ack every cycle
    for (int i = 0; i < 3; i++) put(32'h400 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF);
    done_pulses = 0;
    dmem_ack = 1'b1;
    for (int k = 0; k < 12; k++) begin
      fence_req = (done_pulses == 0) && !(m_fence && sbq.size() == 0);
      st_valid  = fence_req; st_addr = 32'h500 + 32'(4*k); st_data = 32'(k); st_mask = 4'hF;
      step();
    end
    fence_req = 1'b0; st_valid = 1'b0; dmem_ack = 1'b0;
    chk("t4_fence_pulses", 32'(done_pulses), 32'd1);
    drain();

    // fence on an empty buffer
    done_pulses = 0;
    fence_req = 1'b1;
    step();
    fence_req = 1'b0;
    chk("t4_empty_done", 32'(fence_done), 32'd1);
    step();
    step();
    chk("t4_empty_pulses", 32'(done_pulses), 32'd1);

    // simultaneous enqueue and dequeue at count 2
    put(32'h600, 32'h1111_1111, 4'hF);
    put(32'h604, 32'h2222_2222, 4'hF);
    st_valid = 1'b1; st_addr = 32'h608; st_data = 32'h3333_3333; st_mask = 4'hF;
    dmem_ack = 1'b1;
    step();
    st_valid = 1'b0; dmem_ack = 1'b0;
    chk("t5_count", 32'(sb_count), 32'd2);
    drain();

    // random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      st_valid  = 1'($urandom_range(0, 1));
      st_addr   = $urandom;
      st_data   = $urandom;
      st_mask   = 4'($urandom_range(0, 15));
      dmem_ack  = ($urandom_range(0, 2) != 0);
      fence_req = m_fence ? (sbq.size() != 0) : ($urandom_range(0, 49) == 0);
      step();
    end
    st_valid = 1'b0; fence_req = 1'b0;
    if (m_fence) step();
    drain();

    // reset mid-drain discards entries and drops req at once
    put(32'h700, 32'hAAAA_AAAA, 4'hF);
    put(32'h704, 32'hBBBB_BBBB, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("rst_req",   32'(dmem_req), 32'd0);
    chk("rst_count", 32'(sb_count), 32'd0);
    sbq.delete();
    m_fence = 1'b0;
    dmem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    dmem_ack = 1'b0;

`ifdef STORE_BUF_FWD_EN
    // youngest byte wins over the older word store
    put(32'h20, 32'h1122_3344, 4'hF);
    put(32'h21, 32'h0000_0055, 4'h2);
    ld_addr = 32'h20;
    #1;
    chk("fwd_data", ld_fwd_data, 32'h1122_5544);
    chk("fwd_mask", {28'h0, ld_fwd_mask}, 32'h0000_000F);
    ld_addr = 32'h24;
    #1;
    chk("fwd_miss", {28'h0, ld_fwd_mask}, 32'h0000_0000);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
